// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable generator: per channel a one-cycle tick
// every DIV enabled cycles plus a 50% square wave, with glitch-free ratio reload.
`timescale 1ns/1ps

module clk_tick_ch #(
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 99
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_div,
  output logic             o_tick,
  output logic             o_div_clk
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt, div, shadow, ld_val, nxt_div;
  logic             pend, wrap;

  // >= rather than == so a ratio shrunk while disabled still wraps on the next enabled edge
  always_comb begin
    ld_val  = (i_load_div == '0) ? ONE : i_load_div;
    wrap    = (cnt >= div - ONE);
    nxt_div = i_load ? ld_val : (pend ? shadow : div);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      div       <= DEF;
      shadow    <= DEF;
      pend      <= 1'b0;
      o_tick    <= 1'b0;
      o_div_clk <= 1'b0;
    end else if (i_sync) begin
      cnt       <= '0;
      div       <= nxt_div;
      pend      <= 1'b0;
      o_tick    <= 1'b0;
      o_div_clk <= 1'b0;
      if (i_load) shadow <= ld_val;
    end else begin
      if (i_load) shadow <= ld_val;
      if (i_en) begin
        if (wrap) begin
          cnt       <= '0;
          div       <= nxt_div;
          pend      <= 1'b0;
          o_tick    <= 1'b1;
          o_div_clk <= ~o_div_clk;
        end else begin
          cnt    <= cnt + ONE;
          o_tick <= 1'b0;
          if (i_load) pend <= 1'b1;
        end
      end else begin
        // disabled: a pending ratio takes effect right away, a fresh load waits a cycle
        o_tick <= 1'b0;
        if (pend) div <= shadow;
        pend <= i_load;
      end
    end
  end
endmodule

module clk_tick_gen #(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 24,
  parameter  int DEFAULT_DIV = 99,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_sync,
  input  logic              i_load,
  input  logic [CH_W-1:0]   i_load_ch,
  input  logic [CNT_W-1:0]  i_load_div,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_div_clk
);
  // out-of-range channel indices match no lane, so the load is simply dropped
  logic [NUM_CH-1:0] load_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign load_hit[c] = i_load && (i_load_ch == CH_W'(c));

    clk_tick_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en[c]),
      .i_sync     (i_sync),
      .i_load     (load_hit[c]),
      .i_load_div (i_load_div),
      .o_tick     (o_tick[c]),
      .o_div_clk  (o_div_clk[c])
    );
  end
endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen: directed scenarios plus random traffic, scored per cycle
// against a deadline-based reference model through an expected-output queue.
`timescale 1ns/1ps

module tb_clk_tick_gen;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 24;
  localparam int DEF    = 99;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              sync, load;
  logic [CH_W-1:0]   load_ch;
  logic [CNT_W-1:0]  load_div;
  logic [NUM_CH-1:0] tick, div_clk;

  always #5 clk = ~clk;

  clk_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_sync(sync), .i_load(load),
    .i_load_ch(load_ch), .i_load_div(load_div), .o_tick(tick), .o_div_clk(div_clk)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] dclk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // model: rem = enabled edges still owed before the next tick, per = active ratio
  int rem[NUM_CH], per[NUM_CH], pv[NUM_CH];
  bit pend[NUM_CH], mt[NUM_CH], md[NUM_CH];

  task automatic model(input bit r, input logic [NUM_CH-1:0] e, input bit s,
                       input bit ld, input int ch, input int v);
    int lv;
    bit h;
    lv = (v == 0) ? 1 : v;
    for (int c = 0; c < NUM_CH; c++) begin
      h = ld && (ch == c);
      if (r) begin
        rem[c] = DEF; per[c] = DEF; pv[c] = DEF; pend[c] = 0; mt[c] = 0; md[c] = 0;
      end else if (s) begin
        per[c] = h ? lv : (pend[c] ? pv[c] : per[c]);
        rem[c] = per[c]; pend[c] = 0; mt[c] = 0; md[c] = 0;
        if (h) pv[c] = lv;
      end else if (e[c]) begin
        if (rem[c] <= 1) begin
          mt[c] = 1; md[c] = !md[c];
          per[c] = h ? lv : (pend[c] ? pv[c] : per[c]);
          rem[c] = per[c]; pend[c] = 0;
        end else begin
          mt[c] = 0; rem[c]--;
          if (h) pend[c] = 1;
        end
        if (h) pv[c] = lv;
      end else begin
        mt[c] = 0;
        if (pend[c]) begin rem[c] += pv[c] - per[c]; per[c] = pv[c]; end
        pend[c] = h;
        if (h) pv[c] = lv;
      end
    end
  endtask

  task automatic step(input bit r, input logic [NUM_CH-1:0] e, input bit s,
                      input bit ld, input int ch, input int v);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sync = s; load = ld;
    load_ch = CH_W'(ch); load_div = CNT_W'(v);
    model(r, e, s, ld, ch, v);
    for (int c = 0; c < NUM_CH; c++) begin x.tick[c] = mt[c]; x.dclk[c] = md[c]; end
    exp_q.push_back(x);
  endtask

  task automatic run(input int n, input logic [NUM_CH-1:0] e);
    for (int i = 0; i < n; i++) step(0, e, 0, 0, 0, 0);
  endtask

  // monitor: one expected entry per clock edge, sampled just after the edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        n_checks++;
        if (tick !== x.tick) begin
          n_fail++;
          $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, x.tick);
        end
        n_checks++;
        if (div_clk !== x.dclk) begin
          n_fail++;
          $display("FAIL div_clk cyc=%0d got=%b want=%b", cyc, div_clk, x.dclk);
        end
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] re;
    rst = 1'b1; en = '0; sync = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
    // reset state, default ratio, free-run with first tick after 99 edges
    step(1, '1, 0, 0, 0, 0);
    step(1, '1, 0, 0, 0, 0);
    run(420, '1);
    // ch1 to ratio 10 aligned by sync, then reload 4 at cnt=3
    step(0, '1, 0, 1, 1, 10);
    step(0, '1, 1, 0, 0, 0);
    run(13, '1);
    step(0, '1, 0, 1, 1, 4);
    run(30, '1);
    // ratio 0 then 1 on ch0
    step(0, '1, 0, 1, 0, 0);
    run(6, '1);
    step(0, '1, 0, 1, 0, 1);
    run(6, '1);
    // ch2 ratio 9, frozen for 7 cycles mid-count
    step(0, '1, 0, 1, 2, 9);
    step(0, '1, 1, 0, 0, 0);
    run(4, '1);
    run(7, 3'b011);
    run(25, '1);
    // ratios 3/5/7 unaligned, then sync with a pending load on ch0
    step(0, '1, 0, 1, 0, 3);
    step(0, '1, 0, 1, 1, 5);
    run(2, '1);
    step(0, '1, 0, 1, 2, 7);
    run(17, '1);
    step(0, '1, 0, 1, 0, 6);
    step(0, '1, 1, 0, 0, 0);
    run(30, '1);
    // sync with a simultaneous load
    step(0, '1, 1, 1, 1, 2);
    run(12, '1);
    // reset mid-period with a load pending, then out-of-range load
    step(0, '1, 0, 1, 2, 11);
    run(2, '1);
    step(1, '1, 0, 0, 0, 0);
    step(0, '1, 0, 1, 3, 5);
    run(205, '1);
    // random traffic: enables, rare syncs, loads including ratio 0 and bad channels
    for (int i = 0; i < 1500; i++) begin
      re = NUM_CH'($urandom);
      if ($urandom_range(0, 3) != 0) re = '1;
      step(0, re, $urandom_range(0, 60) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3), $urandom_range(0, 12));
    end
    step(0, '1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d entries want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
